// File: rtl/fifo_rd_stream_adapter_if.sv
// Bundle between fifo_rd_stream_adapter, the sync_fifo read port it drives and the downstream sink.
// master = adapter view; slave = FIFO/sink/controller view.
interface fifo_rd_stream_adapter_if #(
    parameter int WIDTH = 80,
    parameter int CNT_W = 32
);
    logic             drain_en;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_empty;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;
    logic [1:0]       buf_cnt;
    logic [CNT_W-1:0] beat_cnt;

    modport master (
        input  drain_en, fifo_dout, fifo_empty, m_ready,
        output fifo_rd_en, m_valid, m_data, buf_cnt, beat_cnt
    );

    modport slave (
        output drain_en, fifo_dout, fifo_empty, m_ready,
        input  fifo_rd_en, m_valid, m_data, buf_cnt, beat_cnt
    );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// sync_fifo read-side master: FIFO words -> valid/ready stream through a 3-entry skid buffer.
// RD_EN to M_VALID is 2 cycles (std) or 1 (FWFT); M_READY only stalls via buffer credits, never combinationally.
module fifo_rd_stream_adapter #(
    parameter int WIDTH     = 80,
    parameter int FWFT_MODE = 0,
    parameter int CNT_W     = 32
) (
    input logic                      clk,
    input logic                      rst,
    fifo_rd_stream_adapter_if.master bus
);
    logic [WIDTH-1:0] buf_mem [3];
    logic [1:0]       wr_ptr;
    logic [1:0]       rd_ptr;
    logic [1:0]       rd_ptr_nxt;
    logic [1:0]       buf_cnt;
    logic [1:0]       buf_cnt_nxt;
    logic             inflight;
    logic [2:0]       committed;
    logic             rd_en;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] m_data_q;
    logic [CNT_W-1:0] beat_cnt;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // A read is only issued when the word it returns is guaranteed a slot.
    assign committed   = {1'b0, buf_cnt} + {2'b00, inflight};
    assign rd_en       = bus.drain_en & ~bus.fifo_empty & ~rst & (committed < 3'd3);
    assign pop         = (buf_cnt != 2'd0) & bus.m_ready;
    assign push        = (FWFT_MODE != 0) ? rd_en : inflight;
    assign rd_ptr_nxt  = pop ? ptr_inc(rd_ptr) : rd_ptr;
    assign buf_cnt_nxt = buf_cnt + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clk) begin
        if (push) begin
            buf_mem[wr_ptr] <= bus.fifo_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            buf_cnt  <= 2'd0;
            inflight <= 1'b0;
            m_data_q <= '0;
            beat_cnt <= '0;
        end else begin
            inflight <= (FWFT_MODE == 0) ? rd_en : 1'b0;
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            rd_ptr  <= rd_ptr_nxt;
            buf_cnt <= buf_cnt_nxt;
            if (pop) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
            // Output register tracks the next head; when the buffer empties it keeps the last word.
            if (buf_cnt_nxt != 2'd0) begin
                m_data_q <= (buf_cnt == {1'b0, pop}) ? bus.fifo_dout : buf_mem[rd_ptr_nxt];
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) push |-> (buf_cnt != 2'd3));

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = (buf_cnt != 2'd0);
    assign bus.m_data     = m_data_q;
    assign bus.buf_cnt    = buf_cnt;
    assign bus.beat_cnt   = beat_cnt;
endmodule
